// File: rtl/adder_settle_capture.sv
// Sequencing stage around a slow combinational adder: launches operands, waits a fixed
// settle time, captures {co,sum} into a small FWFT FIFO and cross-checks the result.
module adder_settle_capture #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int FIFO_DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic             add_co,
  input  logic [WIDTH-1:0] add_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_co,
  output logic [WIDTH-1:0] out_sum,
  output logic             busy,
  output logic [7:0]       ovf_count,
  output logic             chk_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t           state_q, state_d;
  logic [3:0]       settle_q, settle_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             ci_q, ci_d;
  logic [WIDTH:0]   exp_q, exp_d;

  logic [WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_next;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH:0]   head_q, head_d;
  logic [7:0]       ovf_q;
  logic             err_q;

  logic             accept, capture, pop;
  logic [WIDTH:0]   result;

  assign in_ready  = (state_q == IDLE) && (count_q < CNT_W'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign capture   = (state_q == SETTLE) && (settle_q == 4'd0);
  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign result    = {add_co, add_sum};
  assign rd_next   = rd_ptr_q + PTR_W'(1);

  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_ci    = ci_q;
  assign out_co    = head_q[WIDTH];
  assign out_sum   = head_q[WIDTH-1:0];
  assign ovf_count = ovf_q;
  assign chk_err   = err_q;

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    a_d      = a_q;
    b_d      = b_q;
    ci_d     = ci_q;
    exp_d    = exp_q;
    busy     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          a_d      = in_a;
          b_d      = in_b;
          ci_d     = in_ci;
          exp_d    = {1'b0, in_a} + {1'b0, in_b} + (WIDTH+1)'(in_ci);
          settle_d = 4'(SETTLE_CYCLES - 1);
          state_d  = SETTLE;
        end
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_q != 4'd0) settle_d = settle_q - 4'd1;
        else                  state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Head register keeps the FWFT output stable and holds the last value once empty.
  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    if (capture && !pop)      count_d = count_q + CNT_W'(1);
    else if (!capture && pop) count_d = count_q - CNT_W'(1);
    if (pop) begin
      if (count_q > CNT_W'(1)) head_d = mem_q[rd_next];
      else if (capture)        head_d = result;
    end else if (capture && (count_q == '0)) begin
      head_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      settle_q <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      ci_q     <= 1'b0;
      exp_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      ovf_q    <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ci_q     <= ci_d;
      exp_q    <= exp_d;
      count_q  <= count_d;
      head_q   <= head_d;
      if (capture) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_next;
      if (capture && add_co && (ovf_q != 8'hFF)) ovf_q <= ovf_q + 8'd1;
      if (capture && (result != exp_q))          err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem_q[wr_ptr_q] <= result;
  end

  // Accept requires a free slot, so a capture can never land on a full FIFO.
  assert property (@(posedge clk) disable iff (!rst_n)
                   !(capture && (count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_adder_settle_capture.sv
// Bench for adder_settle_capture: models a one-clock-late adder, scoreboards every
// delivered result and checks handshake timing, error flag, reset and saturation.
module tb_adder_settle_capture;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = 4'h0, in_b = 4'h0;
  logic       in_ci = 1'b0;
  logic [3:0] add_a, add_b;
  logic       add_ci;
  logic       add_co;
  logic [3:0] add_sum;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_co;
  logic [3:0] out_sum;
  logic       busy;
  logic [7:0] ovf_count;
  logic       chk_err;

  logic [4:0] adder_q = 5'h00;
  logic       corrupt = 1'b0;
  logic [4:0] sb[$];
  logic [4:0] mon_e;
  int         n_checks = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  // Adder model: output settles one clock after its inputs change.
  always @(posedge clk) adder_q <= {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_ci};
  assign add_co  = adder_q[4];
  assign add_sum = adder_q[3:0] + {3'b0, corrupt};

  adder_settle_capture #(.WIDTH(4), .SETTLE_CYCLES(2), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_ci(in_ci),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci), .add_co(add_co), .add_sum(add_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_co(out_co), .out_sum(out_sum),
    .busy(busy), .ovf_count(ovf_count), .chk_err(chk_err)
  );

  // Scoreboard consumer side: every pop is compared with the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL pop_unexpected got co=%0d sum=%h required no pop", out_co, out_sum);
      end else begin
        mon_e = sb.pop_front();
        if ({out_co, out_sum} !== mon_e)
          $display("FAIL pop_data got co=%0d sum=%h required co=%0d sum=%h",
                   out_co, out_sum, mon_e[4], mon_e[3:0]);
        else begin
          n_pass++;
          $display("pop co=%0d sum=%h", out_co, out_sum);
        end
      end
    end
  end

  task automatic send(input logic [3:0] a, input logic [3:0] b, input logic ci, input logic bad);
    logic [4:0] e;
    bit done = 0;
    e = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    if (bad) e[3:0] = e[3:0] + 4'd1;
    in_a = a; in_b = b; in_ci = ci; in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e);
        done = 1;
      end
    end
    n_checks++;
    if (!done) $display("FAIL send_timeout a=%h b=%h in_ready=0 required 1", a, b);
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    corrupt = bad;
    $display("send a=%h b=%h ci=%0d bad=%0d", a, b, ci, bad);
  endtask

  task automatic wait_valid(input string tag);
    bit seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    n_checks++;
    if (!seen) $display("FAIL %s_timeout out_valid=0 required 1", tag);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({add_a, add_b, add_ci, out_co, out_sum} !== 14'h0)
      $display("FAIL reset_data got a=%h b=%h ci=%0d co=%0d sum=%h required all 0",
               add_a, add_b, add_ci, out_co, out_sum);
    else n_pass++;
    n_checks++;
    if ({out_valid, busy, ovf_count, chk_err} !== 11'h0)
      $display("FAIL reset_status got valid=%0d busy=%0d ovf=%0d err=%0d required all 0",
               out_valid, busy, ovf_count, chk_err);
    else n_pass++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready got %0d required 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_basic();
    out_ready = 1'b0;
    corrupt = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL basic_pre_ready got %0d required 1", in_ready);
    else n_pass++;
    in_a = 4'h3; in_b = 4'h4; in_ci = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    sb.push_back(5'h07);
    $display("send a=3 b=4 ci=0 bad=0");
    @(negedge clk);
    n_checks++;
    if ({add_a, add_b, add_ci, busy, in_ready} !== {4'h3, 4'h4, 1'b0, 1'b1, 1'b0})
      $display("FAIL basic_launch got a=%h b=%h ci=%0d busy=%0d rdy=%0d required 3 4 0 1 0",
               add_a, add_b, add_ci, busy, in_ready);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid, busy} !== 2'b01)
      $display("FAIL basic_settling got valid=%0d busy=%0d required 0 1", out_valid, busy);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({out_valid, out_co, out_sum} !== {1'b1, 1'b0, 4'h7})
      $display("FAIL basic_capture got valid=%0d co=%0d sum=%h required 1 0 7",
               out_valid, out_co, out_sum);
    else n_pass++;
    n_checks++;
    if ({ovf_count, chk_err, busy, in_ready} !== {8'd0, 1'b0, 1'b0, 1'b1})
      $display("FAIL basic_status got ovf=%0d err=%0d busy=%0d rdy=%0d required 0 0 0 1",
               ovf_count, chk_err, busy, in_ready);
    else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL basic_popped got valid=%0d required 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_ovf_pop();
    out_ready = 1'b1;
    send(4'h9, 4'h8, 1'b1, 1'b0);
    wait_valid("ovf1");
    n_checks++;
    if ({out_co, out_sum, ovf_count} !== {1'b1, 4'h2, 8'd1})
      $display("FAIL ovf_first got co=%0d sum=%h ovf=%0d required 1 2 1", out_co, out_sum, ovf_count);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL ovf_single_cycle got valid=%0d required 0", out_valid);
    else n_pass++;
    @(posedge clk); #1;
    send(4'hF, 4'hF, 1'b1, 1'b0);
    wait_valid("ovf2");
    n_checks++;
    if ({out_co, out_sum, ovf_count} !== {1'b1, 4'hF, 8'd2})
      $display("FAIL ovf_second got co=%0d sum=%h ovf=%0d required 1 f 2", out_co, out_sum, ovf_count);
    else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [4:0] e3;
    bit done = 0;
    out_ready = 1'b0;
    send(4'h1, 4'h2, 1'b0, 1'b0);
    send(4'h7, 4'h9, 1'b0, 1'b0);
    e3 = {1'b0, 4'hA} + {1'b0, 4'h4} + 5'd1;
    in_a = 4'hA; in_b = 4'h4; in_ci = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL b2b_held cycle=%0d in_ready=%0d required 0", k, in_ready);
      else n_pass++;
    end
    n_checks++;
    if ({out_valid, add_a, add_b} !== {1'b1, 4'h7, 4'h9})
      $display("FAIL b2b_full got valid=%0d a=%h b=%h required 1 7 9", out_valid, add_a, add_b);
    else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e3);
        done = 1;
      end
    end
    n_checks++;
    if (!done) $display("FAIL b2b_third_timeout in_ready=0 required 1");
    else n_pass++;
    @(posedge clk); #1;
    in_valid = 1'b0;
    $display("send a=a b=4 ci=1 bad=0");
    out_ready = 1'b1;
    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    #1;
    out_ready = 1'b0;
    n_checks++;
    if (sb.size() != 0) $display("FAIL b2b_drain left=%0d required 0", sb.size());
    else n_pass++;
  endtask

  task automatic test_chk_err();
    out_ready = 1'b1;
    n_checks++;
    if (chk_err !== 1'b0) $display("FAIL err_pre got %0d required 0", chk_err);
    else n_pass++;
    send(4'h2, 4'h3, 1'b0, 1'b1);
    wait_valid("err_bad");
    n_checks++;
    if ({chk_err, out_sum} !== {1'b1, 4'h6})
      $display("FAIL err_set got err=%0d sum=%h required 1 6", chk_err, out_sum);
    else n_pass++;
    @(posedge clk); #1;
    send(4'h1, 4'h1, 1'b0, 1'b0);
    wait_valid("err_good");
    n_checks++;
    if ({chk_err, out_sum} !== {1'b1, 4'h2})
      $display("FAIL err_sticky got err=%0d sum=%h required 1 2", chk_err, out_sum);
    else n_pass++;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_settle();
    out_ready = 1'b0;
    send(4'h5, 4'h6, 1'b0, 1'b0);
    wait_valid("mid_first");
    @(posedge clk); #1;
    send(4'h1, 4'h2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    corrupt = 1'b0;
    n_checks++;
    if ({add_a, add_b, add_ci, out_co, out_sum} !== 14'h0)
      $display("FAIL mid_reset_data got a=%h b=%h ci=%0d co=%0d sum=%h required all 0",
               add_a, add_b, add_ci, out_co, out_sum);
    else n_pass++;
    n_checks++;
    if ({out_valid, busy, ovf_count, chk_err} !== 11'h0)
      $display("FAIL mid_reset_status got valid=%0d busy=%0d ovf=%0d err=%0d required all 0",
               out_valid, busy, ovf_count, chk_err);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if ({out_valid, busy} !== 2'b00)
      $display("FAIL mid_no_capture got valid=%0d busy=%0d required 0 0", out_valid, busy);
    else n_pass++;
    @(posedge clk); #1;
    test_basic();
  endtask

  task automatic test_saturate();
    int want;
    out_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send(4'hF, 4'hF, 1'b1, 1'b0);
      wait_valid("sat");
      want = (i + 1 > 255) ? 255 : i + 1;
      if (i == 0 || i == 253 || i == 254 || i == 255 || i == 299) begin
        n_checks++;
        if (ovf_count !== want[7:0])
          $display("FAIL sat_count op=%0d got %0d required %0d", i, ovf_count, want);
        else n_pass++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_checks++;
    if (sb.size() != 0) $display("FAIL sat_drain left=%0d required 0", sb.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ovf_pop();
    test_back_to_back();
    test_chk_err();
    test_reset_mid_settle();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish required finish");
    $fatal(1, "watchdog");
  end

endmodule
